// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared encodings for the multicycle controller (states, opcodes, ALU/mux selects).
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state constants, opcode constants, ALUOp codes, ALUSrcB/PCSource encodings
//           and the DECODE dispatch function. Honours MC_CTRL_JUMP_EN (jump support).
package mc_ctrl_pkg;

    // State register encoding; plain constants keep the encoding fixed for older tools.
    typedef logic [3:0] state_t;

    localparam state_t S_INIT     = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_MEMADR   = 4'd3;
    localparam state_t S_MEMRD    = 4'd4;
    localparam state_t S_MEMWB    = 4'd5;
    localparam state_t S_MEMWR    = 4'd6;
    localparam state_t S_RTYPE_EX = 4'd7;
    localparam state_t S_RTYPE_WB = 4'd8;
    localparam state_t S_BEQ_EX   = 4'd9;
    localparam state_t S_ADDI_EX  = 4'd10;
    localparam state_t S_ADDI_WB  = 4'd11;
    localparam state_t S_JUMP     = 4'd12;
    localparam state_t S_ILLEGAL  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Narrow ALU op codes; the top zero-extends them to the configured width.
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_SEXT  = 2'b10,
        SRCB_SHIFT = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    // DECODE dispatch: anything not recognised becomes an illegal-instruction trap.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:     nxt = S_RTYPE_EX;
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_BEQ:       nxt = S_BEQ_EX;
            OP_ADDI:      nxt = S_ADDI_EX;
`ifdef MC_CTRL_JUMP_EN
            OP_J:         nxt = S_JUMP;
`endif
            default:      nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// Purpose : wrapping count of retired instructions.
// Latency : count reflects an increment on the edge ending the inc cycle.
// Backpressure: none; inc is sampled every cycle.
// Ports   : clk, rst_n (async active-low clear), inc (retire pulse), count (CNT_W).
module mc_retire_counter
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Natural modular wrap from all-ones back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Purpose : Moore FSM generating datapath controls for a multicycle MIPS-style core.
// Latency : R 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles; +1 per MEM_READY=0 cycle in a memory state.
// Backpressure: FETCH/MEMRD/MEMWR hold until MEM_READY=1.
// Ports   : CLK, RST_N (async active-low), OPCODE, MEM_READY in; datapath controls,
//           PCSource, ALUSrcB, ALUOp (ALUOP_W), Exception, INSTR_DONE, RETIRED (CNT_W) out.
// Config  : define MC_CTRL_JUMP_EN to execute opcode 000010 as a jump; otherwise it traps.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [5:0]         OPCODE,
    input  logic               MEM_READY,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Exception,
    output logic               INSTR_DONE,
    output logic [CNT_W-1:0]   RETIRED
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       retire;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Outputs depend only on state (and MEM_READY in memory states), so the
    // async reset into INIT drives every output low immediately.
    always_comb begin
        next_state  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcB     = SRCB_REG;
        alu_op      = ALUOP_ADD;
        Exception   = 1'b0;
        retire      = 1'b0;
        case (state)
            S_INIT: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // IR and PC+4 commit only in the cycle the fetch completes.
                IRWrite = MEM_READY;
                PCWrite = MEM_READY;
                if (MEM_READY) next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_SHIFT;
                next_state = decode_next(OPCODE);
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_SEXT;
                next_state = (OPCODE == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MEM_READY) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                // A store retires only in the cycle memory accepts it.
                retire   = MEM_READY;
                if (MEM_READY) next_state = S_FETCH;
            end
            S_RTYPE_EX: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ_EX: begin
                ALUSrcA     = 1'b1;
                alu_op      = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_SEXT;
                next_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
`ifdef MC_CTRL_JUMP_EN
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
`endif
            S_ILLEGAL: begin
                // Trap does not retire and writes no architectural state.
                Exception  = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_INIT;
            end
        endcase
    end

    assign ALUOp      = {{(ALUOP_W-2){1'b0}}, alu_op};
    assign INSTR_DONE = retire;

    mc_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (retire),
        .count (RETIRED)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : scoreboard bench for multicycle_control (CNT_W=4, ALUOP_W=5).
// Latency : expectations are queued one per cycle by the driver and popped by a monitor.
// Backpressure: MEM_READY stalls are driven explicitly per cycle.
module tb_multicycle_control;

    localparam int ALUOP_W = 5;
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       irw;
        logic       asa;
        logic       rw;
        logic       rd;
        logic [1:0] pcs;
        logic [1:0] asb;
        logic [4:0] aluop;
        logic       exc;
        logic       done;
    } ctl_t;

    logic               CLK;
    logic               RST_N;
    logic [5:0]         OPCODE;
    logic               MEM_READY;
    logic               PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic               MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]         PCSource;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic               Exception;
    logic               INSTR_DONE;
    logic [CNT_W-1:0]   RETIRED;

    multicycle_control #(
        .ALUOP_W (ALUOP_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .OPCODE      (OPCODE),
        .MEM_READY   (MEM_READY),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .Exception   (Exception),
        .INSTR_DONE  (INSTR_DONE),
        .RETIRED     (RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    ctl_t             exp_w_q[$];
    logic [CNT_W-1:0] exp_r_q[$];
    string            exp_n_q[$];
    logic [CNT_W-1:0] exp_ret;

    // Hand-derived control word for each state of the controller.
    function automatic ctl_t e(input string st, input bit mr);
        ctl_t c;
        c = '0;
        case (st)
            "FETCH":    begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
            "DECODE":   begin c.asb = 2'b11; end
            "MEMADR":   begin c.asa = 1; c.asb = 2'b10; end
            "MEMRD":    begin c.iord = 1; c.mrd = 1; end
            "MEMWB":    begin c.m2r = 1; c.rw = 1; c.done = 1; end
            "MEMWR":    begin c.iord = 1; c.mwr = 1; c.done = mr; end
            "RTYPE_EX": begin c.asa = 1; c.aluop = 5'd2; end
            "RTYPE_WB": begin c.rd = 1; c.rw = 1; c.done = 1; end
            "BEQ_EX":   begin c.asa = 1; c.aluop = 5'b00001; c.pcwc = 1; c.pcs = 2'b01; c.done = 1; end
            "ADDI_EX":  begin c.asa = 1; c.asb = 2'b10; end
            "ADDI_WB":  begin c.rw = 1; c.done = 1; end
            "JUMP":     begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; end
            "ILLEGAL":  begin c.exc = 1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input string st, input bit mr);
        ctl_t c;
        c = e(st, mr);
        exp_w_q.push_back(c);
        exp_r_q.push_back(exp_ret);
        exp_n_q.push_back(st);
        if (c.done) exp_ret = exp_ret + 1'b1;
    endtask

    // Called at posedge+1: drive this cycle's inputs, queue its expectation, advance.
    task automatic cyc(input string st, input bit mr);
        MEM_READY = mr;
        push(st, mr);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every sampled cycle with a queued expectation is one comparison.
    always @(negedge CLK) begin
        if (exp_w_q.size() > 0) begin
            ctl_t             w;
            ctl_t             got;
            logic [CNT_W-1:0] r;
            string            n;
            w   = exp_w_q.pop_front();
            r   = exp_r_q.pop_front();
            n   = exp_n_q.pop_front();
            got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
                   ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, Exception, INSTR_DONE};
            checks++;
            if (got !== w || RETIRED !== r) begin
                errors++;
                $display("FAIL %s @%0t: got ctl=%h retired=%0d, expected ctl=%h retired=%0d",
                         n, $time, got, RETIRED, w, r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N     = 1'b0;
        OPCODE    = 6'b000000;
        MEM_READY = 1'b0;
        exp_ret   = '0;

        // Reset held, then released mid-cycle: INIT for one cycle, FETCH after the next edge.
        @(posedge CLK); #1;
        push("INIT", 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        push("INIT", 0);
        @(posedge CLK); #1;

        // lw, no stalls: 5 cycles, retires once.
        OPCODE = 6'b100011;
        cyc("FETCH", 1); cyc("DECODE", 1); cyc("MEMADR", 1); cyc("MEMRD", 1); cyc("MEMWB", 1);

        // sw with three MEMWR stall cycles.
        OPCODE = 6'b101011;
        cyc("FETCH", 1); cyc("DECODE", 1); cyc("MEMADR", 1);
        for (int i = 0; i < 3; i++) cyc("MEMWR", 0);
        cyc("MEMWR", 1);

        // Illegal opcode traps without retiring.
        OPCODE = 6'b111111;
        cyc("FETCH", 1); cyc("DECODE", 1); cyc("ILLEGAL", 1);

        // Jump: executes or traps depending on build.
        OPCODE = 6'b000010;
        cyc("FETCH", 1); cyc("DECODE", 1);
`ifdef MC_CTRL_JUMP_EN
        cyc("JUMP", 1);
`else
        cyc("ILLEGAL", 1);
`endif

        // R-type with two fetch stalls.
        OPCODE = 6'b000000;
        cyc("FETCH", 0); cyc("FETCH", 0); cyc("FETCH", 1);
        cyc("DECODE", 1); cyc("RTYPE_EX", 1); cyc("RTYPE_WB", 1);

        // addi.
        OPCODE = 6'b001000;
        cyc("FETCH", 1); cyc("DECODE", 1); cyc("ADDI_EX", 1); cyc("ADDI_WB", 1);

        // lw with one MEMRD stall.
        OPCODE = 6'b100011;
        cyc("FETCH", 1); cyc("DECODE", 1); cyc("MEMADR", 1);
        cyc("MEMRD", 0); cyc("MEMRD", 1); cyc("MEMWB", 1);

        // 16 beq: the 4-bit counter passes through 15 -> 0.
        OPCODE = 6'b000100;
        for (int i = 0; i < 16; i++) begin
            cyc("FETCH", 1); cyc("DECODE", 1); cyc("BEQ_EX", 1);
        end

        // Reset pulse in the middle of a MEMRD wait.
        OPCODE = 6'b100011;
        cyc("FETCH", 1); cyc("DECODE", 1); cyc("MEMADR", 1); cyc("MEMRD", 0);
        MEM_READY = 1'b0;
        #1;
        RST_N   = 1'b0;
        exp_ret = '0;
        push("INIT", 0);
        @(posedge CLK); #1;
        push("INIT", 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        push("INIT", 0);
        @(posedge CLK); #1;

        // Machine restarts cleanly after the pulse.
        OPCODE = 6'b001000;
        cyc("FETCH", 1); cyc("DECODE", 1); cyc("ADDI_EX", 1); cyc("ADDI_WB", 1);
        cyc("FETCH", 0);

        repeat (2) @(negedge CLK);
        checks++;
        if (exp_w_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_w_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
